// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter: round-robin arbiter merging two write requesters onto one RAM write port.
// Optional memory-clear sequencer is enabled by defining RAM_WRITE_ARBITER_CLEAR_EN.
module ram_write_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_SIZE   = 8
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iReq0,
   input  logic                  iReq1,
   input  logic [ADDR_WIDTH-1:0] iAddr0,
   input  logic [ADDR_WIDTH-1:0] iAddr1,
   input  logic [DATA_WIDTH-1:0] iData0,
   input  logic [DATA_WIDTH-1:0] iData1,
   output logic                  oGrant0,
   output logic                  oGrant1,
   input  logic                  iClearStart,
   output logic                  oBusy,
   output logic                  oWriteEnable,
   output logic [ADDR_WIDTH-1:0] oWriteAddress,
   output logic [DATA_WIDTH-1:0] oWriteData
);
   logic                  grant0_q, grant0_d, grant1_q, grant1_d;
   logic                  we_q, we_d, last_q, last_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  pick0, pick1;
`ifdef RAM_WRITE_ARBITER_CLEAR_EN
   typedef enum logic {ARB, CLEAR} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  busy_q, busy_d, done;
`else
   logic                  unused_clear;
   assign unused_clear = iClearStart;
`endif
   // last_q set means requester 1 was granted most recently, so requester 0 wins a tie
   always_comb begin
      pick1    = iReq1 & ~grant1_q & (~(iReq0 & ~grant0_q) | ~last_q);
      pick0    = iReq0 & ~grant0_q & ~pick1;
      grant0_d = pick0;
      grant1_d = pick1;
      we_d     = pick0 | pick1;
      addr_d   = pick1 ? iAddr1 : pick0 ? iAddr0 : addr_q;
      data_d   = pick1 ? iData1 : pick0 ? iData0 : data_q;
      last_d   = pick1 ? 1'b1 : pick0 ? 1'b0 : last_q;
`ifdef RAM_WRITE_ARBITER_CLEAR_EN
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = 1'b0;
      done     = cnt_q == ADDR_WIDTH'(MEM_SIZE);
      if (state_q == CLEAR || iClearStart) begin
         grant0_d = 1'b0;
         grant1_d = 1'b0;
         last_d   = last_q;
         data_d   = '0;
      end
      if (state_q == CLEAR) begin
         we_d    = ~done;
         busy_d  = ~done;
         cnt_d   = done ? cnt_q : cnt_q + 1'b1;
         addr_d  = done ? addr_q : cnt_q + 1'b1;
         state_d = done ? ARB : CLEAR;
      end else if (iClearStart) begin
         we_d    = 1'b1;
         busy_d  = 1'b1;
         cnt_d   = '0;
         addr_d  = '0;
         state_d = CLEAR;
      end
`endif
   end
   always_ff @(posedge Clock) begin
      if (Reset) begin
         grant0_q <= 1'b0;
         grant1_q <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         last_q   <= 1'b1;
`ifdef RAM_WRITE_ARBITER_CLEAR_EN
         state_q  <= ARB;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
`endif
      end else begin
         grant0_q <= grant0_d;
         grant1_q <= grant1_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         last_q   <= last_d;
`ifdef RAM_WRITE_ARBITER_CLEAR_EN
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
`endif
      end
   end
   assign oGrant0       = grant0_q;
   assign oGrant1       = grant1_q;
   assign oWriteEnable  = we_q;
   assign oWriteAddress = addr_q;
   assign oWriteData    = data_q;
`ifdef RAM_WRITE_ARBITER_CLEAR_EN
   assign oBusy = busy_q;
`else
   assign oBusy = 1'b0;
`endif
endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb_ram_write_arbiter: directed bench for ram_write_arbiter with a small RAM model on the write port.
// Clear-sequence checks follow RAM_WRITE_ARBITER_CLEAR_EN.
module tb_ram_write_arbiter;
   localparam int DW = 16, AW = 8, MS = 8;
   logic          clk = 1'b0, rst = 1'b1;
   logic          req0 = 0, req1 = 0, clr = 0;
   logic [AW-1:0] a0 = '0, a1 = '0;
   logic [DW-1:0] d0 = '0, d1 = '0;
   logic          g0, g1, busy, we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] mem [0:255];
   int            checks = 0, errors = 0;

   always #5 clk = ~clk;

   ram_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
      .Clock(clk), .Reset(rst), .iReq0(req0), .iReq1(req1), .iAddr0(a0), .iAddr1(a1),
      .iData0(d0), .iData1(d1), .oGrant0(g0), .oGrant1(g1), .iClearStart(clr), .oBusy(busy),
      .oWriteEnable(we), .oWriteAddress(waddr), .oWriteData(wdata));

   always @(posedge clk) if (we) mem[waddr] <= wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic outs(input string tag, input logic eg0, input logic eg1, input logic ewe,
                       input logic [AW-1:0] ea, input logic [DW-1:0] ed, input logic eb);
      chk({tag, ".g0"}, 32'(g0), 32'(eg0));
      chk({tag, ".g1"}, 32'(g1), 32'(eg1));
      chk({tag, ".we"}, 32'(we), 32'(ewe));
      chk({tag, ".addr"}, 32'(waddr), 32'(ea));
      chk({tag, ".data"}, 32'(wdata), 32'(ed));
      chk({tag, ".busy"}, 32'(busy), 32'(eb));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      // reset wins over a request and a clear pulse on the same edge
      req0 = 1; a0 = 8'd3; d0 = 16'hABCD; clr = 1;
      tick; tick;
      outs("reset", 0, 0, 0, 0, 0, 0);
      clr = 0; rst = 0;
      tick;
      outs("single", 1, 0, 1, 8'd3, 16'hABCD, 0);
      tick;
      outs("single_once", 0, 0, 0, 8'd3, 16'hABCD, 0);
      req0 = 0;
      tick;
      outs("idle", 0, 0, 0, 8'd3, 16'hABCD, 0);

      rst = 1; tick; rst = 0;
      req0 = 1; a0 = 8'd1; d0 = 16'h1111;
      req1 = 1; a1 = 8'd2; d1 = 16'h2222;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (i % 2 == 0) outs($sformatf("tie%0d", i), 1, 0, 1, 8'd1, 16'h1111, 0);
         else            outs($sformatf("tie%0d", i), 0, 1, 1, 8'd2, 16'h2222, 0);
      end
      req0 = 0; req1 = 0;
      tick;
      req0 = 1;
      tick;
      outs("solo0", 1, 0, 1, 8'd1, 16'h1111, 0);
      req0 = 0;
      tick;
      req0 = 1; req1 = 1;
      tick;
      outs("rr_after0", 0, 1, 1, 8'd2, 16'h2222, 0);
      req0 = 0; req1 = 0;
      tick; tick;

`ifdef RAM_WRITE_ARBITER_CLEAR_EN
      clr = 1; req1 = 1; a1 = 8'd2; d1 = 16'h2222;
      tick;
      outs("clr0", 0, 0, 1, 8'd0, 16'h0, 1);
      for (int i = 1; i <= MS; i++) begin
         clr = (i == 4);
         tick;
         outs($sformatf("clr%0d", i), 0, 0, 1, AW'(i), 16'h0, 1);
      end
      clr = 0;
      tick;
      outs("clr_end", 0, 0, 0, AW'(MS), 16'h0, 0);
      for (int i = 0; i <= MS; i++) chk($sformatf("mem%0d", i), 32'(mem[i]), 32'h0);
      tick;
      outs("post_clr_grant", 0, 1, 1, 8'd2, 16'h2222, 0);
      req1 = 0;
      tick;
      for (int i = 0; i <= MS; i++) mem[i] = 16'h5000 + 16'(i);
      clr = 1;
      tick;
      clr = 0;
      repeat (4) tick;
      outs("abort_at4", 0, 0, 1, 8'd4, 16'h0, 1);
      rst = 1;
      tick;
      outs("abort_rst", 0, 0, 0, 0, 0, 0);
      rst = 0;
      tick; tick;
      outs("abort_after", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) chk($sformatf("abort_mem%0d", i), 32'(mem[i]), 32'h0);
      for (int i = 5; i <= MS; i++) chk($sformatf("abort_mem%0d", i), 32'(mem[i]), 32'h5000 + i);
`else
      clr = 1;
      tick;
      outs("noclr", 0, 0, 0, 8'd2, 16'h2222, 0);
      clr = 0;
      tick;
      outs("noclr_after", 0, 0, 0, 8'd2, 16'h2222, 0);
      chk("noclr_mem0", 32'(mem[0]), 32'h1000);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
